// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger arbiter: operation and error codes,
// default amount width and the ledger FSM state encoding.
package atm_pkg;

  localparam int AMT_W = 21;

  typedef enum logic [1:0] {
    OP_BAL = 2'b00,
    OP_WD  = 2'b01,
    OP_DEP = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_FUNDS = 2'b01,
    ERR_OVF   = 2'b10,
    ERR_ILL   = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  // Width of a terminal index; never zero, even for a single terminal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting terminal
// after last_grant_i, wrapping around. The rotation pointer lives in the parent.
module atm_rr_arbiter #(
  parameter int NUM_TERM = 2,
  parameter int IDX_W    = atm_pkg::idx_w(NUM_TERM)
) (
  input  logic [NUM_TERM-1:0] req_i,
  input  logic [IDX_W-1:0]    last_grant_i,
  output logic [NUM_TERM-1:0] grant_o
);

  function automatic int rr_index(input int base, input int off);
    int idx;
    idx = base + off;
    if (idx >= NUM_TERM) idx = idx - NUM_TERM;
    return idx;
  endfunction

  logic found;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_TERM; i++) begin
      if (!found && req_i[rr_index(int'(last_grant_i), i)]) begin
        grant_o[rr_index(int'(last_grant_i), i)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Round-robin shared balance ledger for NUM_TERM ATM terminals.
// Define ATM_WD_LIMIT_EN to reject withdrawals above MAX_WITHDRAW with the illegal/limit error.
module atm_ledger_arbiter #(
  parameter int                         NUM_TERM     = 2,
  parameter int                         AMT_W        = atm_pkg::AMT_W,
  parameter logic [AMT_W-1:0]           INIT_BALANCE = 21'd10000,
  parameter logic [AMT_W-1:0]           MAX_WITHDRAW = 21'd5000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_TERM-1:0]       req_valid,
  input  logic [2*NUM_TERM-1:0]     req_op,
  input  logic [AMT_W*NUM_TERM-1:0] req_amount,
  output logic [NUM_TERM-1:0]       req_ready,
  output logic [NUM_TERM-1:0]       rsp_valid,
  output logic                      rsp_ok,
  output logic [1:0]                rsp_err,
  output logic [AMT_W-1:0]          balance_amount
);

  import atm_pkg::*;

  localparam int IDX_W = idx_w(NUM_TERM);

  state_e               state_q;
  logic [IDX_W-1:0]     last_grant_q;
  op_e                  op_q;
  logic [AMT_W-1:0]     amt_q;
  logic [NUM_TERM-1:0]  gnt_q;
  logic [AMT_W-1:0]     balance_q, balance_d;
  logic [NUM_TERM-1:0]  rsp_valid_q;
  logic                 rsp_ok_q, rsp_ok_d;
  err_e                 rsp_err_q, rsp_err_d;

  logic [NUM_TERM-1:0]  grant;
  logic [IDX_W-1:0]     grant_idx;
  op_e                  op_sel;
  logic [AMT_W-1:0]     amt_sel;
  logic [AMT_W:0]       dep_sum;

  atm_rr_arbiter #(
    .NUM_TERM (NUM_TERM),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_TERM; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
    op_sel  = op_e'(req_op[2*int'(grant_idx) +: 2]);
    amt_sel = req_amount[AMT_W*int'(grant_idx) +: AMT_W];
  end

  // Accept only while idle and out of reset, so the handshake is silent during reset.
  assign req_ready = (state_q == S_IDLE && !reset) ? grant : '0;

  // Transaction outcome, evaluated against the latched request during EXEC.
  always_comb begin
    balance_d = balance_q;
    rsp_ok_d  = 1'b1;
    rsp_err_d = ERR_NONE;
    dep_sum   = {1'b0, balance_q} + {1'b0, amt_q};
    case (op_q)
      OP_BAL: ;
      OP_WD: begin
`ifdef ATM_WD_LIMIT_EN
        if (amt_q > MAX_WITHDRAW) begin
          rsp_ok_d  = 1'b0;
          rsp_err_d = ERR_ILL;
        end else
`endif
        if (amt_q > balance_q) begin
          rsp_ok_d  = 1'b0;
          rsp_err_d = ERR_FUNDS;
        end else begin
          balance_d = balance_q - amt_q;
        end
      end
      OP_DEP: begin
        if (dep_sum[AMT_W]) begin
          rsp_ok_d  = 1'b0;
          rsp_err_d = ERR_OVF;
        end else begin
          balance_d = dep_sum[AMT_W-1:0];
        end
      end
      default: begin
        rsp_ok_d  = 1'b0;
        rsp_err_d = ERR_ILL;
      end
    endcase
  end

`ifndef ATM_WD_LIMIT_EN
  logic unused_wd_cap;
  assign unused_wd_cap = ^MAX_WITHDRAW;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NUM_TERM - 1);
      op_q         <= OP_BAL;
      amt_q        <= '0;
      gnt_q        <= '0;
      balance_q    <= INIT_BALANCE;
      rsp_valid_q  <= '0;
      rsp_ok_q     <= 1'b0;
      rsp_err_q    <= ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          rsp_valid_q <= '0;
          if (|grant) begin
            op_q         <= op_sel;
            amt_q        <= amt_sel;
            gnt_q        <= grant;
            last_grant_q <= grant_idx;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          balance_q   <= balance_d;
          rsp_ok_q    <= rsp_ok_d;
          rsp_err_q   <= rsp_err_d;
          rsp_valid_q <= gnt_q;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= '0;
          state_q     <= S_IDLE;
        end
        default: begin
          rsp_valid_q <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_ok         = rsp_ok_q;
  assign rsp_err        = rsp_err_q;
  assign balance_amount = balance_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed bench for atm_ledger_arbiter with two terminals and hand-computed expectations.
module tb_atm_ledger_arbiter;

  localparam int NUM_TERM = 2;
  localparam int AMT_W    = 21;

  logic                      clk;
  logic                      reset;
  logic [NUM_TERM-1:0]       req_valid;
  logic [2*NUM_TERM-1:0]     req_op;
  logic [AMT_W*NUM_TERM-1:0] req_amount;
  logic [NUM_TERM-1:0]       req_ready;
  logic [NUM_TERM-1:0]       rsp_valid;
  logic                      rsp_ok;
  logic [1:0]                rsp_err;
  logic [AMT_W-1:0]          balance_amount;

  int n_checks = 0;
  int n_errors = 0;
  logic [AMT_W-1:0] exp_bal;

  atm_ledger_arbiter #(
    .NUM_TERM     (NUM_TERM),
    .AMT_W        (AMT_W),
    .INIT_BALANCE (21'd10000),
    .MAX_WITHDRAW (21'd5000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_amount     (req_amount),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ok         (rsp_ok),
    .rsp_err        (rsp_err),
    .balance_amount (balance_amount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Single-terminal transaction with fixed 3-cycle latency.
  task automatic run_txn(input string tag, input int t, input logic [1:0] op,
                         input logic [AMT_W-1:0] amt, input logic exp_ok,
                         input logic [1:0] exp_err, input logic [AMT_W-1:0] bal);
    @(negedge clk);
    req_valid[t]                = 1'b1;
    req_op[2*t +: 2]            = op;
    req_amount[AMT_W*t +: AMT_W] = amt;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'(1 << t));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1 check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << t));
    check({tag, "_rsp_ok"},    32'(rsp_ok),    32'(exp_ok));
    check({tag, "_rsp_err"},   32'(rsp_err),   32'(exp_err));
    check({tag, "_balance"},   32'(balance_amount), 32'(bal));
  endtask

  // Both terminals deposit 100 at once; rotation must serve T0 then T1.
  task automatic run_pair(input string tag);
    @(negedge clk);
    req_valid  = 2'b11;
    req_op     = {2'b10, 2'b10};
    req_amount = {21'd100, 21'd100};
    #1 check({tag, "_grant_t0"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1 check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    exp_bal = exp_bal + 21'd100;
    check({tag, "_rsp_t0"},  32'(rsp_valid), 32'd1);
    check({tag, "_bal_t0"},  32'(balance_amount), 32'(exp_bal));
    check({tag, "_resp_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    #1 check({tag, "_grant_t1"}, 32'(req_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    exp_bal = exp_bal + 21'd100;
    check({tag, "_rsp_t1"}, 32'(rsp_valid), 32'd2);
    check({tag, "_ok_t1"},  32'(rsp_ok), 32'd1);
    check({tag, "_bal_t1"}, 32'(balance_amount), 32'(exp_bal));
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b11;
    req_op     = '0;
    req_amount = '0;
    #12;
    check("rst_ready",     32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_ok",    32'(rsp_ok), 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_balance",   32'(balance_amount), 32'd10000);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    exp_bal = 21'd10000;

    run_txn("bal_t0", 0, 2'b00, 21'd0, 1'b1, 2'b00, exp_bal);
    exp_bal = 21'd9500;
    run_txn("wd500_t0", 0, 2'b01, 21'd500, 1'b1, 2'b00, exp_bal);
    run_txn("wd20000_t1", 1, 2'b01, 21'd20000, 1'b0, 2'b01, exp_bal);
    run_txn("wd0_t0", 0, 2'b01, 21'd0, 1'b1, 2'b00, exp_bal);
    run_txn("dep0_t1", 1, 2'b10, 21'd0, 1'b1, 2'b00, exp_bal);

    run_pair("pair1");
    run_pair("pair2");

    // Climb to 2^21-100, then overflow and illegal-op cases.
    run_txn("dep_fill", 0, 2'b10, 21'd2097052 - exp_bal, 1'b1, 2'b00, 21'd2097052);
    exp_bal = 21'd2097052;
    run_txn("dep_ovf", 1, 2'b10, 21'd200, 1'b0, 2'b10, exp_bal);
    run_txn("op_ill", 0, 2'b11, 21'd5, 1'b0, 2'b11, exp_bal);
    run_txn("wd_all", 1, 2'b01, 21'd2097052, 1'b1, 2'b00, 21'd0);
    exp_bal = 21'd0;
    run_txn("wd_empty", 0, 2'b01, 21'd1, 1'b0, 2'b01, exp_bal);
    run_txn("dep_refill", 1, 2'b10, 21'd777, 1'b1, 2'b00, 21'd777);

    // Reset lands while a withdraw of 300 is executing.
    @(negedge clk);
    req_valid  = 2'b01;
    req_op     = 2'b01;
    req_amount = {21'd0, 21'd300};
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("midrst_balance", 32'(balance_amount), 32'd10000);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1 check("midrst_idle_ready", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(negedge clk);
    check("midrst_quiet1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("midrst_quiet2", 32'(rsp_valid), 32'd0);
    check("midrst_bal_hold", 32'(balance_amount), 32'd10000);

`ifdef ATM_WD_LIMIT_EN
    run_txn("wd6000_cap", 0, 2'b01, 21'd6000, 1'b0, 2'b11, 21'd10000);
`else
    run_txn("wd6000_nocap", 0, 2'b01, 21'd6000, 1'b1, 2'b00, 21'd4000);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
